// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions: op encodings, default widths, valid-op table and
// decode helpers used by the ALU, the arbiter top level and the bench.
// No ports; imported with `import alu_share_arb_pkg::*;`.
package alu_share_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 5;

  localparam logic [OP_W_DEF-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W_DEF-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W_DEF-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_W_DEF-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W_DEF-1:0] ALU_XOR  = 5'd4;
  localparam logic [OP_W_DEF-1:0] ALU_SLL  = 5'd5;
  localparam logic [OP_W_DEF-1:0] ALU_SRL  = 5'd6;
  localparam logic [OP_W_DEF-1:0] ALU_SRA  = 5'd7;
  localparam logic [OP_W_DEF-1:0] ALU_SLT  = 5'd8;
  localparam logic [OP_W_DEF-1:0] ALU_SLTU = 5'd9;
  localparam logic [OP_W_DEF-1:0] ALU_BEQ  = 5'd10;
  localparam logic [OP_W_DEF-1:0] ALU_BNE  = 5'd11;
  localparam logic [OP_W_DEF-1:0] ALU_BLT  = 5'd12;
  localparam logic [OP_W_DEF-1:0] ALU_BGE  = 5'd13;
  localparam logic [OP_W_DEF-1:0] ALU_BLTU = 5'd14;
  localparam logic [OP_W_DEF-1:0] ALU_BGEU = 5'd15;

  localparam int ALU_NUM_OPS = 16;
  localparam logic [OP_W_DEF-1:0] ALU_VALID_OPS [ALU_NUM_OPS] = '{
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  };

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic alu_op_valid(input logic [OP_W_DEF-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < ALU_NUM_OPS; i++) begin
      if (op == ALU_VALID_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Compare ops report their outcome only through the zero flag.
  function automatic logic alu_op_is_cmp(input logic [OP_W_DEF-1:0] op);
    return (op == ALU_BEQ) || (op == ALU_BNE) || (op == ALU_BLT) ||
           (op == ALU_BGE) || (op == ALU_BLTU) || (op == ALU_BGEU);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU shared by the execute stage and helpers.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: op/src1/src2 in; result out; zero out (result==0, or compare outcome).
module alu
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic              cmp_op;
  logic              cmp;
  logic [SH_W-1:0]   shamt;

  // Native shift behaviour: only the low SH_W bits of src2 are used.
  assign shamt = src2[SH_W-1:0];

  always_comb begin
    result = '0;
    cmp_op = 1'b0;
    cmp    = 1'b0;
    case (op)
      ALU_ADD:  result = src1 + src2;
      ALU_SUB:  result = src1 - src2;
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_SLL:  result = src1 << shamt;
      ALU_SRL:  result = src1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(src1) >>> shamt);
      ALU_SLT:  result = DATA_W'($signed(src1) < $signed(src2));
      ALU_SLTU: result = DATA_W'(src1 < src2);
      ALU_BEQ:  begin cmp_op = 1'b1; cmp = (src1 == src2); end
      ALU_BNE:  begin cmp_op = 1'b1; cmp = (src1 != src2); end
      ALU_BLT:  begin cmp_op = 1'b1; cmp = ($signed(src1) < $signed(src2)); end
      ALU_BGE:  begin cmp_op = 1'b1; cmp = ($signed(src1) >= $signed(src2)); end
      ALU_BLTU: begin cmp_op = 1'b1; cmp = (src1 < src2); end
      ALU_BGEU: begin cmp_op = 1'b1; cmp = (src1 >= src2); end
      default:  result = '0;
    endcase
  end

  assign zero = cmp_op ? cmp : (result == '0);

endmodule

// File: rtl/alu_arb_pick.sv
// Two-way grant picker for the shared ALU; optional macro ALU_ARB_RR_EN
// selects round-robin (else fixed priority, port 0 wins). Latency: 0 cycles.
// Backpressure: no grant while en=0. Ports: clk/rst_n, en (slot free),
// v0/v1 request valids in; gnt0/gnt1 one-hot grants out.
module alu_arb_pick (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic v0,
  input  logic v1,
  output logic gnt0,
  output logic gnt1
);

  logic pick0;  // winner on contention: 1 = port 0

`ifdef ALU_ARB_RR_EN
  // last = port granted most recently; resets to 1 so port 0 wins first.
  logic last;

  assign pick0 = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last <= gnt1;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;
  assign pick0          = 1'b1;
`endif

  assign gnt0 = en & v0 & (~v1 | pick0);
  assign gnt1 = en & v1 & (~v0 | ~pick0);

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters with a single registered response.
// Latency: accepted at edge N, rsp_valid from N+1; 1 op/cycle when drained.
// Backpressure: rsp_ready=0 while FULL holds the response and drops both readies.
// Ports: req0_*/req1_* valid/ready + op/src1/src2; rsp_valid/rsp_ready with
// rsp_id/rsp_result/rsp_zero/rsp_err. Optional macro: ALU_ARB_RR_EN.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  rsp_state_e        state_q, state_d;
  logic              slot_free;
  logic              accept;
  logic [OP_W-1:0]   op_sel;
  logic [DATA_W-1:0] src1_sel, src2_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              op_ok, op_cmp;

  // A held response that leaves this cycle frees the slot for a new one.
  assign slot_free = (state_q == RSP_EMPTY) | rsp_ready;

  alu_arb_pick u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (slot_free),
    .v0    (req0_valid),
    .v1    (req1_valid),
    .gnt0  (req0_ready),
    .gnt1  (req1_ready)
  );

  assign accept   = req0_ready | req1_ready;
  assign op_sel   = req1_ready ? req1_op   : req0_op;
  assign src1_sel = req1_ready ? req1_src1 : req0_src1;
  assign src2_sel = req1_ready ? req1_src2 : req0_src2;

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op     (op_sel),
    .src1   (src1_sel),
    .src2   (src2_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign op_ok  = alu_op_valid(op_sel);
  assign op_cmp = alu_op_is_cmp(op_sel);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !accept) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Undefined ops and compares never forward the ALU's result bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      rsp_id     <= req1_ready;
      rsp_result <= (op_ok && !op_cmp) ? alu_result : '0;
      rsp_zero   <= op_ok ? alu_zero : 1'b0;
      rsp_err    <= ~op_ok;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);

endmodule
